// File: rtl/cpu_ir_pkg.sv
// Instruction-word field positions and widths shared by the IR decoder and the control unit.
package cpu_ir_pkg;

  localparam int unsigned INS_W = 32;

  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SA_MSB    = 10;
  localparam int unsigned SA_LSB    = 6;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_MSB   = 15;
  localparam int unsigned IMM_LSB   = 0;
  localparam int unsigned JADDR_MSB = 25;
  localparam int unsigned JADDR_LSB = 0;

  localparam int unsigned OP_W    = OP_MSB - OP_LSB + 1;
  localparam int unsigned REG_W   = RS_MSB - RS_LSB + 1;
  localparam int unsigned SA_W    = SA_MSB - SA_LSB + 1;
  localparam int unsigned FUNCT_W = FUNCT_MSB - FUNCT_LSB + 1;
  localparam int unsigned IMM_W   = IMM_MSB - IMM_LSB + 1;
  localparam int unsigned JADDR_W = JADDR_MSB - JADDR_LSB + 1;

endpackage

// File: rtl/ir_prefetch_queue_if.sv
// Fetch-side valid/ready handshake between instruction memory and the prefetch queue.
interface ir_prefetch_queue_if;
  import cpu_ir_pkg::*;

  logic [INS_W-1:0] Ins_Data;
  logic             Ins_Valid;
  logic             Ins_Ready;

  modport master (output Ins_Data, output Ins_Valid, input Ins_Ready);
  modport slave  (input Ins_Data, input Ins_Valid, output Ins_Ready);

endinterface

// File: rtl/ir_queue_fifo.sv
// Circular instruction buffer: storage, read/write pointers and occupancy count.
module ir_queue_fifo
  import cpu_ir_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   Reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [INS_W-1:0]       wdata,
  output logic [INS_W-1:0]       rdata_c,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full_c,
  output logic                   empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [INS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign do_push = push && !full_c && !clear;
  assign do_pop  = pop && !empty_c && !clear;
  assign rdata_c = mem[rptr];

  // Storage carries no reset; only words below count are ever observed.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ir_prefetch_queue.sv
// Prefetch queue in front of the instruction register, with empty-queue bypass,
// redirect flush and MIPS field decode of the IR.
module ir_prefetch_queue
  import cpu_ir_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   Reset_n,
  ir_prefetch_queue_if.slave     fetch,
  input  logic                   IRWre,
  input  logic                   Flush,
  output logic                   IR_Valid,
  output logic [OP_W-1:0]        Op_code,
  output logic [REG_W-1:0]       Rs_reg,
  output logic [REG_W-1:0]       Rt_reg,
  output logic [REG_W-1:0]       Rd_reg,
  output logic [SA_W-1:0]        Sa_number,
  output logic [FUNCT_W-1:0]     Funct,
  output logic [IMM_W-1:0]       Imm_number,
  output logic [JADDR_W-1:0]     Jump_addr,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Full,
  output logic                   Empty
);

  logic [INS_W-1:0] ir;
  logic [INS_W-1:0] head_c;
  logic             fire_c;
  logic             bypass_c;
  logic             push_c;
  logic             pop_c;

  // Ready depends only on registered occupancy and Flush, never on IRWre.
  assign fetch.Ins_Ready = !Full && !Flush;
  assign fire_c          = fetch.Ins_Valid && fetch.Ins_Ready;
  assign bypass_c        = Empty && IRWre && fire_c;
  assign push_c          = fire_c && !bypass_c;
  assign pop_c           = IRWre && !Empty;

  ir_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .push    (push_c),
    .pop     (pop_c),
    .clear   (Flush),
    .wdata   (fetch.Ins_Data),
    .rdata_c (head_c),
    .count   (Count),
    .full_c  (Full),
    .empty_c (Empty)
  );

  // Flush only invalidates; the fields keep the last word for debug visibility.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      ir       <= '0;
      IR_Valid <= 1'b0;
    end else if (Flush) begin
      IR_Valid <= 1'b0;
    end else if (IRWre) begin
      if (!Empty) begin
        ir       <= head_c;
        IR_Valid <= 1'b1;
      end else if (bypass_c) begin
        ir       <= fetch.Ins_Data;
        IR_Valid <= 1'b1;
      end else begin
        IR_Valid <= 1'b0;
      end
    end
  end

  assign Op_code    = ir[OP_MSB:OP_LSB];
  assign Rs_reg     = ir[RS_MSB:RS_LSB];
  assign Rt_reg     = ir[RT_MSB:RT_LSB];
  assign Rd_reg     = ir[RD_MSB:RD_LSB];
  assign Sa_number  = ir[SA_MSB:SA_LSB];
  assign Funct      = ir[FUNCT_MSB:FUNCT_LSB];
  assign Imm_number = ir[IMM_MSB:IMM_LSB];
  assign Jump_addr  = ir[JADDR_MSB:JADDR_LSB];

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Bench for ir_prefetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_ir_prefetch_queue;
  import cpu_ir_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        IRWre;
  logic        Flush;
  logic        IR_Valid;
  logic [5:0]  Op_code;
  logic [4:0]  Rs_reg, Rt_reg, Rd_reg, Sa_number;
  logic [5:0]  Funct;
  logic [15:0] Imm_number;
  logic [25:0] Jump_addr;
  logic [2:0]  Count;
  logic        Full, Empty;

  ir_prefetch_queue_if fif ();

  ir_prefetch_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .fetch(fif), .IRWre(IRWre), .Flush(Flush),
    .IR_Valid(IR_Valid), .Op_code(Op_code), .Rs_reg(Rs_reg), .Rt_reg(Rt_reg),
    .Rd_reg(Rd_reg), .Sa_number(Sa_number), .Funct(Funct), .Imm_number(Imm_number),
    .Jump_addr(Jump_addr), .Count(Count), .Full(Full), .Empty(Empty)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: an in-order list of queued words plus the IR contents.
  logic [31:0] m_q[$];
  logic [31:0] m_ir;
  bit          m_valid;

  function automatic logic [31:0] dut_ir();
    return {Op_code, Rs_reg, Rt_reg, Rd_reg, Sa_number, Funct};
  endfunction

  function automatic logic [5:0] dut_status();
    return {Count, Full, Empty, IR_Valid};
  endfunction

  function automatic logic [5:0] exp_status();
    return {3'(m_q.size()), m_q.size() == DEPTH, m_q.size() == 0, m_valid};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ir    = '0;
    m_valid = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] d, input bit w, input bit f);
    bit acc;
    acc = v && (m_q.size() < DEPTH) && !f;
    if (f) begin
      m_q.delete();
      m_valid = 1'b0;
    end else if (w) begin
      if (m_q.size() > 0) begin
        m_ir    = m_q.pop_front();
        m_valid = 1'b1;
        if (acc) m_q.push_back(d);
      end else if (acc) begin
        m_ir    = d;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end else if (acc) begin
      m_q.push_back(d);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit w, input bit f);
    fif.Ins_Valid = v;
    fif.Ins_Data  = d;
    IRWre         = w;
    Flush         = f;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge(fif.Ins_Valid, fif.Ins_Data, IRWre, Flush);
    #1;
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    model_reset();
    #12;
    checks++;
    if ({dut_status(), fif.Ins_Ready} !== {6'b000_0_1_0, 1'b1}) begin
      errors++;
      $display("FAIL reset_status: got %b want %b", {dut_status(), fif.Ins_Ready}, 7'b0000101);
    end
    checks++;
    if ({dut_ir(), Imm_number, Jump_addr} !== 74'd0) begin
      errors++;
      $display("FAIL reset_fields: got %h want 0", {dut_ir(), Imm_number, Jump_addr});
    end
    @(negedge CLK);
    Reset_n = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_fill_drain();
    logic [31:0] prog [3];
    prog[0] = 32'h8C22_0004;
    prog[1] = 32'h0043_2020;
    prog[2] = 32'h1000_FFFF;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, prog[i], 1'b0, 1'b0);
      tick();
    end
    checks++;
    if ({Count, fif.Ins_Ready, IR_Valid} !== {3'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fill_count_ready_valid: got %b want %b", {Count, fif.Ins_Ready, IR_Valid}, 5'b01110);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    checks++;
    if ({Op_code, Rs_reg, Rt_reg, Imm_number, IR_Valid} !== {6'h23, 5'd1, 5'd2, 16'h0004, 1'b1}) begin
      errors++;
      $display("FAIL pop_lw: got op=%h rs=%0d rt=%0d imm=%h v=%b", Op_code, Rs_reg, Rt_reg, Imm_number, IR_Valid);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    checks++;
    if ({Rd_reg, Funct, Count} !== {5'd4, 6'h20, 3'd1}) begin
      errors++;
      $display("FAIL pop_add: got rd=%0d funct=%h count=%0d want rd=4 funct=20 count=1", Rd_reg, Funct, Count);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    checks++;
    if ({Imm_number, Empty, dut_ir()} !== {16'hFFFF, 1'b1, prog[2]}) begin
      errors++;
      $display("FAIL pop_beq: got imm=%h empty=%b ir=%h want imm=ffff empty=1 ir=%h", Imm_number, Empty, dut_ir(), prog[2]);
    end
  endtask

  task automatic test_full();
    logic [31:0] w [DEPTH];
    logic [31:0] extra, late;
    for (int i = 0; i < DEPTH; i++) begin
      w[i] = $urandom;
      drive(1'b1, w[i], 1'b0, 1'b0);
      tick();
    end
    extra = $urandom;
    drive(1'b1, extra, 1'b0, 1'b0);
    #1;
    checks++;
    if ({Full, Count, fif.Ins_Ready} !== {1'b1, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL full_flags: got full=%b count=%0d ready=%b want 1 4 0", Full, Count, fif.Ins_Ready);
    end
    tick();
    checks++;
    if (Count !== 3'd4) begin
      errors++;
      $display("FAIL full_extra_dropped: got count=%0d want 4", Count);
    end
    // Pop at full frees one slot; the same-cycle word is refused.
    drive(1'b1, extra, 1'b1, 1'b0);
    tick();
    checks++;
    if ({Count, dut_ir()} !== {3'd3, w[0]}) begin
      errors++;
      $display("FAIL full_pop: got count=%0d ir=%h want 3 %h", Count, dut_ir(), w[0]);
    end
    late = $urandom;
    drive(1'b1, late, 1'b1, 1'b0);
    tick();
    checks++;
    if ({Count, dut_ir()} !== {3'd3, w[1]}) begin
      errors++;
      $display("FAIL push_pop_same_cycle: got count=%0d ir=%h want 3 %h", Count, dut_ir(), w[1]);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
      checks++;
      if (dut_ir() !== ((i == 2) ? late : w[i+2])) begin
        errors++;
        $display("FAIL fifo_order_%0d: got %h want %h", i, dut_ir(), (i == 2) ? late : w[i+2]);
      end
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 32'h0800_0010, 1'b1, 1'b0);
    tick();
    checks++;
    if ({Jump_addr, Op_code, IR_Valid, Count} !== {26'h000_0010, 6'h02, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL bypass: got jaddr=%h op=%h v=%b count=%0d want 0000010 02 1 0", Jump_addr, Op_code, IR_Valid, Count);
    end
  endtask

  task automatic test_bubble();
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    checks++;
    if ({IR_Valid, dut_ir()} !== {1'b0, 32'h0800_0010}) begin
      errors++;
      $display("FAIL bubble: got v=%b ir=%h want 0 08000010", IR_Valid, dut_ir());
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    #1;
    checks++;
    if (fif.Ins_Ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got %b want 0", fif.Ins_Ready);
    end
    tick();
    checks++;
    if ({Count, IR_Valid, dut_ir()} !== {3'd0, 1'b0, 32'h0800_0010}) begin
      errors++;
      $display("FAIL flush: got count=%0d v=%b ir=%h want 0 0 08000010", Count, IR_Valid, dut_ir());
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    checks++;
    if ({Empty, IR_Valid, dut_ir()} !== {1'b1, 1'b0, 32'h0800_0010}) begin
      errors++;
      $display("FAIL flush_discard: got empty=%b v=%b ir=%h want 1 0 08000010", Empty, IR_Valid, dut_ir());
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h2108_0001, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h2108_0002, 1'b1, 1'b0);
    tick();
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({dut_status(), dut_ir(), fif.Ins_Ready} !== {6'b000_0_1_0, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got st=%b ir=%h rdy=%b want 000010 0 1", dut_status(), dut_ir(), fif.Ins_Ready);
    end
    model_reset();
    @(negedge CLK);
    Reset_n = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      #1;
      checks++;
      if (fif.Ins_Ready !== ((m_q.size() < DEPTH) && !Flush)) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b want %b", i, fif.Ins_Ready, (m_q.size() < DEPTH) && !Flush);
      end
      tick();
      checks++;
      if (dut_status() !== exp_status()) begin
        errors++;
        $display("FAIL rand_status[%0d]: got %b want %b", i, dut_status(), exp_status());
      end
      checks++;
      if ({dut_ir(), Imm_number, Jump_addr} !== {m_ir, m_ir[15:0], m_ir[25:0]}) begin
        errors++;
        $display("FAIL rand_ir[%0d]: got %h want %h", i, dut_ir(), m_ir);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full();
    test_bypass();
    test_bubble();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
